// File: rtl/bias_trim_ctrl_pkg.sv
// bias_trim_ctrl_pkg: register map, ctrl/status bit indices and serial frame layout
package bias_trim_ctrl_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int FRAME_BITS = 16;
  localparam int FRAME_W_BIT = 15;
  localparam int FRAME_ADDR_LO = 12;
  localparam int FRAME_DATA_LO = 0;
  localparam int READ_BIT = 8;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd5;
  localparam int CTRL_EN = 0;
  localparam int CTRL_BYPASS = 1;
  localparam int STATUS_BUSY = 0;
endpackage

// File: rtl/bias_trim_spi_if.sv
// bias_trim_spi_if: synchronised serial slave turning frames into a write strobe and read-back shifter
module bias_trim_spi_if
  import bias_trim_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  logic [FRAME_BITS-1:0] sr;
  logic [4:0] cnt;
  logic [DATA_W-1:0] tx;
  logic act, rd, ld, rise, fall, cs_fall, cs_rise, win;
  assign rise = sclk_q[1] & ~sclk_q[2];
  assign fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall = ~cs_q[1] & cs_q[2];
  assign cs_rise = cs_q[1] & ~cs_q[2];
  assign win = cnt >= 5'(READ_BIT) && cnt < 5'(FRAME_BITS);
  // once the first byte is in, sr[7:0] holds frame bits 15..8
  assign rd_addr = sr[FRAME_ADDR_LO-READ_BIT +: ADDR_W];
  // cs sync flops reset low so a cs_n held low through reset is never taken as a frame start
  always_ff @(posedge clk)
    if (rst) begin
      sclk_q <= '0;
      cs_q <= '0;
      mosi_q <= '0;
      sr <= '0;
      cnt <= '0;
      tx <= '0;
      act <= 1'b0;
      rd <= 1'b0;
      ld <= 1'b0;
      miso <= 1'b0;
      wr_stb <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
      wr_stb <= act & cs_rise & (cnt == 5'(FRAME_BITS)) & sr[FRAME_W_BIT];
      wr_addr <= sr[FRAME_ADDR_LO +: ADDR_W];
      wr_data <= sr[FRAME_DATA_LO +: DATA_W];
      ld <= act & rise & (cnt == 5'(READ_BIT-1));
      act <= cs_fall ? 1'b1 : cs_rise ? 1'b0 : act;
      cnt <= cs_fall ? '0 : (act & rise & cnt != 5'(FRAME_BITS)) ? cnt + 5'd1 : cnt;
      sr <= (act & rise & cnt != 5'(FRAME_BITS)) ? {sr[FRAME_BITS-2:0], mosi_q[1]} : sr;
      rd <= cs_fall ? 1'b0 : ld ? ~sr[FRAME_W_BIT-READ_BIT] : rd;
      tx <= ld ? rd_data : (fall & win) ? tx << 1 : tx;
      miso <= !act ? 1'b0 : fall ? rd & win & tx[DATA_W-1] : miso;
    end
endmodule

// File: rtl/bias_trim_ctrl.sv
// bias_trim_ctrl: serially programmed bias trim codes ramped one LSB per prescaler tick
module bias_trim_ctrl
  import bias_trim_ctrl_pkg::*;
#(
  parameter int CH = 4,
  parameter int CODE_W = 6,
  parameter int STEP_DIV = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic [CH*CODE_W-1:0] trim,
  output logic               bias_en,
  output logic               busy
);
  logic wr_stb, en, bypass, tick, unused_wr;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [CH-1:0][CODE_W-1:0] target, cur, eff;
  logic [CH-1:0] diff;
  logic [15:0] pre;
  bias_trim_spi_if u_spi (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );
  assign unused_wr = ^wr_data;
  assign tick = pre == 16'(STEP_DIV-1);
  assign trim = cur;
  assign busy = |diff;
  assign bias_en = en | busy;
  always_comb begin
    eff = '0;
    diff = '0;
    for (int i = 0; i < CH; i++) begin
      eff[i] = en ? target[i] : '0;
      diff[i] = cur[i] != eff[i];
    end
  end
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CH; i++)
      if (rd_addr == ADDR_W'(i)) rd_data[CODE_W-1:0] = target[i];
    if (rd_addr == ADDR_CTRL) begin
      rd_data[CTRL_EN] = en;
      rd_data[CTRL_BYPASS] = bypass;
    end
    if (rd_addr == ADDR_STATUS) rd_data[STATUS_BUSY] = busy;
  end
  // bypass follows the effective target directly; otherwise step one LSB per tick, never wrapping
  always_ff @(posedge clk)
    if (rst) begin
      target <= '0;
      cur <= '0;
      en <= 1'b0;
      bypass <= 1'b0;
      pre <= '0;
    end else begin
      pre <= tick ? '0 : pre + 16'd1;
      if (wr_stb && wr_addr == ADDR_CTRL) begin
        en <= wr_data[CTRL_EN];
        bypass <= wr_data[CTRL_BYPASS];
      end
      for (int i = 0; i < CH; i++) begin
        if (wr_stb && wr_addr == ADDR_W'(i)) target[i] <= wr_data[CODE_W-1:0];
        cur[i] <= bypass ? eff[i] : !(tick && diff[i]) ? cur[i] :
                  cur[i] < eff[i] ? cur[i] + CODE_W'(1) : cur[i] - CODE_W'(1);
      end
    end
endmodule

// File: tb/tb_bias_trim_ctrl.sv
// tb_bias_trim_ctrl: directed serial frames with a register-model scoreboard for read-back
module tb_bias_trim_ctrl;
  localparam int H = 8;
  logic clk = 1'b0;
  logic rst, sclk, cs_n, mosi, miso, bias_en, busy;
  logic [23:0] trim;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_tgt[4];
  logic [7:0] m_ctrl;
  logic m_busy;

  bias_trim_ctrl #(.CH(4), .CODE_W(6), .STEP_DIV(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .trim(trim), .bias_en(bias_en), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $error("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [15:0] f, input int nbits, input bit raise, output logic [7:0] rx);
    rx = '0;
    cs_n = 1'b0;
    clks(H);
    for (int i = 0; i < nbits; i++) begin
      mosi = f[15-i];
      clks(H);
      if (i >= 8 && i < 16) rx = {rx[6:0], miso};
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
    end
    clks(H);
    if (raise) cs_n = 1'b1;
  endtask

  function automatic logic [7:0] model(input logic [2:0] a);
    return a < 3'd4 ? m_tgt[a[1:0]] : a == 3'd4 ? m_ctrl : a == 3'd5 ? {7'b0, m_busy} : 8'h00;
  endfunction

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] rx;
    xfer({1'b1, a, 4'h0, d}, 16, 1'b1, rx);
    if (a < 3'd4) m_tgt[a[1:0]] = d & 8'h3F;
    if (a == 3'd4) m_ctrl = d & 8'h03;
    clks(H);
  endtask

  task automatic rd(input logic [2:0] a);
    logic [7:0] rx, e;
    exp_q.push_back(model(a));
    xfer({1'b0, a, 12'h000}, 16, 1'b1, rx);
    clks(H);
    e = exp_q.pop_front();
    check($sformatf("rd_addr%0d", a), {24'h0, rx}, {24'h0, e});
    check("miso_idle", {31'h0, miso}, 32'h0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_tgt[i] = 8'h00;
    m_ctrl = 8'h00;
    m_busy = 1'b0;
  endtask

  initial begin
    int n;
    bit ok, ok2;
    logic [5:0] prev;
    logic [7:0] rx;
    int first, bcnt;
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    model_reset();
    clks(3);
    check("rst_trim", {8'h0, trim}, 32'h0);
    check("rst_bias_en", {31'h0, bias_en}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_miso", {31'h0, miso}, 32'h0);
    rst = 1'b0;
    clks(4);

    wr(3'd4, 8'h01);
    rd(3'd4);

    // ramp ch0 up to 0x20: 32 ticks of 4 clk each
    xfer({1'b1, 3'd0, 4'h0, 8'h20}, 16, 1'b1, rx);
    m_tgt[0] = 8'h20;
    n = 0; ok = 1;
    while (trim[5:0] != 6'h20 && n < 400) begin
      clks(1); n++;
      if (n >= 6 && trim[5:0] != 6'h20 && busy !== 1'b1) ok = 0;
    end
    check("ramp_up_time", {31'h0, n >= 124 && n <= 136}, 32'h1);
    check("ramp_up_busy", {31'h0, ok}, 32'h1);
    check("ramp_up_done_busy", {31'h0, busy}, 32'h0);

    // disable: ramp back down with bias_en held during ramp
    xfer({1'b1, 3'd4, 4'h0, 8'h00}, 16, 1'b1, rx);
    m_ctrl = 8'h00;
    n = 0; ok = 1; ok2 = 1; prev = trim[5:0];
    while (trim[5:0] != 6'h00 && n < 400) begin
      clks(1); n++;
      if (trim[5:0] != prev && trim[5:0] != prev - 6'd1) ok = 0;
      if (trim[5:0] != 6'h00 && bias_en !== 1'b1) ok2 = 0;
      prev = trim[5:0];
    end
    check("ramp_down_time", {31'h0, n >= 124 && n <= 136}, 32'h1);
    check("ramp_down_steps", {31'h0, ok}, 32'h1);
    check("ramp_down_bias_en", {31'h0, ok2}, 32'h1);
    check("ramp_down_end_busy", {31'h0, busy}, 32'h0);
    check("ramp_down_end_bias_en", {31'h0, bias_en}, 32'h0);

    // 10-bit frame aborted by early cs_n rise
    xfer({1'b1, 3'd1, 4'h0, 8'h3F}, 10, 1'b1, rx);
    clks(2 * H);
    check("abort_trim", {8'h0, trim}, 32'h0);
    rd(3'd1);

    // bypass: ch2 follows the target almost at once
    wr(3'd4, 8'h03);
    clks(4);
    xfer({1'b1, 3'd2, 4'h0, 8'h15}, 16, 1'b1, rx);
    m_tgt[2] = 8'h15;
    first = -1; bcnt = 0;
    for (int i = 1; i <= 12; i++) begin
      clks(1);
      if (busy === 1'b1) bcnt++;
      if (first < 0 && trim[17:12] == 6'h15) first = i;
    end
    check("bypass_latency", {31'h0, first >= 1 && first <= 6}, 32'h1);
    check("bypass_busy_cycles", {31'h0, bcnt <= 1}, 32'h1);

    wr(3'd0, 8'h2A);
    clks(4);
    check("bypass_trim", {8'h0, trim}, {8'h0, 6'h00, 6'h15, 6'h00, 6'h2A});
    rd(3'd0);
    rd(3'd7);
    rd(3'd4);

    // ramp on ch3, read status mid-ramp
    wr(3'd4, 8'h01);
    wr(3'd3, 8'h30);
    m_busy = 1'b1;
    rd(3'd5);
    m_busy = 1'b0;
    clks(100);
    check("ch3_settled", {26'h0, trim[23:18]}, 32'h30);

    // reset mid-ramp and mid-frame
    wr(3'd3, 8'h00);
    xfer({1'b1, 3'd1, 4'h0, 8'h3F}, 6, 1'b0, rx);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    clks(1);
    check("midrst_trim", {8'h0, trim}, 32'h0);
    check("midrst_bias_en", {31'h0, bias_en}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_miso", {31'h0, miso}, 32'h0);
    rst = 1'b0;
    model_reset();
    xfer({1'b1, 3'd1, 4'h0, 8'h3F} << 6, 10, 1'b1, rx);
    clks(2 * H);
    check("post_rst_trim", {8'h0, trim}, 32'h0);
    rd(3'd1);
    wr(3'd1, 8'h11);
    rd(3'd1);
    rd(3'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bias_trim_ctrl.md
BIAS_TRIM_CTRL -- requirements
Module: bias_trim_ctrl

Interface
REQ-001 Parameter CH, default 4: number of bias trim channels.
REQ-002 Parameter CODE_W, default 6: width of each trim code.
REQ-003 Parameter STEP_DIV, default 64: clk cycles per ramp step, legal range 2..65535.
REQ-004 clk  in  1  sole clock; every flop SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 sclk  in  1  serial clock, asynchronous to clk.
REQ-007 cs_n  in  1  serial frame select, active-low, asynchronous.
REQ-008 mosi  in  1  serial data in, asynchronous.
REQ-009 miso  out  1  serial data out.
REQ-010 trim  out  CH*CODE_W  current trim codes to the bias generator; channel k occupies bits [k*CODE_W +: CODE_W].
REQ-011 bias_en  out  1  enable to the bias generator.
REQ-012 busy  out  1  high while any channel's current code differs from its effective target.

Function
REQ-013 sclk, cs_n and mosi SHALL each pass through a 2-flop synchroniser; sclk edges SHALL be detected from the synchronised value.
REQ-014 A frame is cs_n low; mosi SHALL be sampled on each detected sclk rising edge, MSB first; bit counter 0..16 saturates at 16.
REQ-015 Frame format: bit15 = W (1 write / 0 read), bits14:12 = addr, bits11:8 ignored, bits7:0 = data.
REQ-016 Register map: addr 0..CH-1 = target[k] (data[CODE_W-1:0]); addr 4 = ctrl (bit0 en, bit1 bypass); addr 5 = status, read-only (bit0 busy); all other addresses read 0 and ignore writes.
REQ-017 A write SHALL commit on the synchronised cs_n rising edge only if exactly 16 bits were received; any other count SHALL be discarded without side effects.
REQ-018 On a read, after bit 8 the addressed register value SHALL be loaded and shifted out MSB first on miso, one bit per detected sclk falling edge, for bits 8..15; at all other times miso SHALL be 0.
REQ-019 The prescaler SHALL count 0..STEP_DIV-1 and pulse tick for one cycle at wrap; it runs continuously from reset.
REQ-020 Effective target[k] SHALL be target[k] when en=1 and 0 when en=0.
REQ-021 On tick with bypass=0, each channel with current != effective target SHALL move exactly 1 LSB toward it; all channels step in the same cycle; no wrap-around past 0 or 2^CODE_W-1.
REQ-022 With bypass=1, current SHALL equal effective target one clk after any change, independent of tick.
REQ-023 A target write during a ramp SHALL retarget immediately; the direction may reverse on the next tick.
REQ-024 bias_en SHALL be 1 when en=1, or when en=0 and busy=1 (stay enabled during ramp-down); otherwise 0.
REQ-025 busy SHALL be combinational from the registered current and effective target values.

Reset
REQ-026 While rst=1: all targets, ctrl, current codes, prescaler, bit counter, shift register and miso SHALL be 0; trim=0, bias_en=0, busy=0 one cycle after rst is asserted.
REQ-027 rst asserted mid-frame SHALL abort the frame; the first frame after release SHALL require a fresh cs_n falling edge.

Structure
REQ-028 A shared package SHALL hold the register address constants, the ctrl bit indices and the frame field positions.
REQ-029 One sub-module, bias_trim_spi_if (synchroniser, shifter, frame decode), SHALL present a one-cycle write strobe with addr/data plus a read-address/read-data port; ramp and prescaler logic SHALL stay in the top level.

Verification
REQ-030 Write target0=0x20 with en=1, STEP_DIV=4 -> trim ch0 rises 0->0x20 in 32 ticks (128 clk +/-4); busy is 1 throughout and then falls.
REQ-031 Then write en=0 -> ch0 ramps 0x20->0 one LSB per tick; bias_en stays 1 until trim=0 and busy=0, then drops.
REQ-032 Abort a 10-bit frame (cs_n high early) targeting target1=0x3F -> no register change, trim unchanged.
REQ-033 Set bypass=1, en=1, write target2=0x15 -> ch2 equals 0x15 within 2 clk of commit, busy never set for more than 1 clk.
REQ-034 Read addr 0 after writing 0x2A -> miso returns 0x2A on bits 8..15; read addr 7 -> 0x00.
REQ-035 Assert rst for 1 clk mid-ramp and mid-frame -> all outputs 0 next cycle; the next complete frame decodes correctly.
